// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Hazard and sequencing controller for the 5-stage pipeline. Drives the
//   enable/flush pair of every pipeline latch plus the PC enable, sequences
//   the end-of-program dcache flush into a permanent halt, and keeps a
//   saturating count of RUN cycles in which the PC was held.
//
// Ports
//   CLK, nRST                 clock (rising edge), async active-low reset
//   ihit, dhit                fetch / MEM data access completes this cycle
//   mem_dren, mem_dwen        MEM-stage load / store request
//   ex_memread, ex_rt         EX instruction is a load, and its destination
//   id_rs, id_rt              source registers of the ID instruction
//   id_jump                   ID instruction is J/JAL/JR
//   mem_branch_taken          branch in MEM resolved taken
//   wb_halt                   HALT has reached the MEM/WB latch output
//   dflush_done               dcache write-back flush complete
//   pc_en                     PC load enable
//   {fl,dl,el,ml}_{en,flush}  IF/ID, ID/EX, EX/MEM, MEM/WB latch controls
//   dflush_req                dcache flush request
//   halted                    processor halted
//   stall_cnt                 RUN cycles with pc_en=0 (saturating)
module pipeline_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dren,
    input  logic             mem_dwen,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_jump,
    input  logic             mem_branch_taken,
    input  logic             wb_halt,
    input  logic             dflush_done,
    output logic             pc_en,
    output logic             fl_en,
    output logic             fl_flush,
    output logic             dl_en,
    output logic             dl_flush,
    output logic             el_en,
    output logic             el_flush,
    output logic             ml_en,
    output logic             ml_flush,
    output logic             dflush_req,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state, next_state;
    logic   mem_stall;
    logic   load_use;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (&v) ? v : v + one;
    endfunction

    assign mem_stall = (mem_dren | mem_dwen) & ~dhit;
    // $zero never carries a real dependency, so a load to r0 cannot stall.
    assign load_use  = ex_memread & (ex_rt != 5'd0) &
                       ((ex_rt == id_rs) | (ex_rt == id_rt));

    // State register and stall counter
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= RUN;
            stall_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == RUN && !pc_en)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

    // Next state and latch controls
    always_comb begin
        next_state = state;
        pc_en      = 1'b0;
        fl_en      = 1'b0;
        fl_flush   = 1'b0;
        dl_en      = 1'b0;
        dl_flush   = 1'b0;
        el_en      = 1'b0;
        el_flush   = 1'b0;
        ml_en      = 1'b0;
        ml_flush   = 1'b0;
        dflush_req = 1'b0;
        halted     = 1'b0;

        case (state)
            RUN: begin
                if (wb_halt) begin
                    // Whole pipeline stops the cycle HALT retires.
                    next_state = FLUSH;
                end else if (mem_stall) begin
                    // Frozen: a taken branch waiting in EX/MEM redirects
                    // only once its data access completes.
                end else if (mem_branch_taken) begin
                    // Younger instructions are squashed, so branch wins
                    // over load-use and jump.
                    pc_en    = 1'b1;
                    fl_flush = 1'b1;
                    dl_flush = 1'b1;
                    el_flush = 1'b1;
                    ml_en    = 1'b1;
                end else if (load_use) begin
                    dl_flush = 1'b1;
                    el_en    = 1'b1;
                    ml_en    = 1'b1;
                end else if (id_jump) begin
                    pc_en    = 1'b1;
                    fl_flush = 1'b1;
                    dl_en    = 1'b1;
                    el_en    = 1'b1;
                    ml_en    = 1'b1;
                end else if (!ihit) begin
                    fl_flush = 1'b1;
                    dl_en    = 1'b1;
                    el_en    = 1'b1;
                    ml_en    = 1'b1;
                end else begin
                    pc_en = 1'b1;
                    fl_en = 1'b1;
                    dl_en = 1'b1;
                    el_en = 1'b1;
                    ml_en = 1'b1;
                end
            end
            FLUSH: begin
                dflush_req = 1'b1;
                if (dflush_done)
                    next_state = HALTED;
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                next_state = RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
//   Directed-vector bench for pipeline_ctrl. Control outputs are packed as
//   {pc_en, fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush, ml_en, ml_flush}.
module tb_pipeline_ctrl;

    localparam int CW = 16;

    // Expected control bundles
    localparam logic [8:0] C_IDLE   = 9'b1_10_10_10_10;
    localparam logic [8:0] C_LOADU  = 9'b0_00_01_10_10;
    localparam logic [8:0] C_BRANCH = 9'b1_01_01_01_10;
    localparam logic [8:0] C_JUMP   = 9'b1_01_10_10_10;
    localparam logic [8:0] C_IMISS  = 9'b0_01_10_10_10;
    localparam logic [8:0] C_NONE   = 9'b0_00_00_00_00;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          ihit, dhit, mem_dren, mem_dwen, ex_memread;
    logic [4:0]    ex_rt, id_rs, id_rt;
    logic          id_jump, mem_branch_taken, wb_halt, dflush_done;
    logic          pc_en, fl_en, fl_flush, dl_en, dl_flush;
    logic          el_en, el_flush, ml_en, ml_flush;
    logic          dflush_req, halted;
    logic [CW-1:0] stall_cnt;
    logic [8:0]    ctl;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    assign ctl = {pc_en, fl_en, fl_flush, dl_en, dl_flush,
                  el_en, el_flush, ml_en, ml_flush};

    pipeline_ctrl #(.CNT_W(CW)) dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .ihit             (ihit),
        .dhit             (dhit),
        .mem_dren         (mem_dren),
        .mem_dwen         (mem_dwen),
        .ex_memread       (ex_memread),
        .ex_rt            (ex_rt),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_jump          (id_jump),
        .mem_branch_taken (mem_branch_taken),
        .wb_halt          (wb_halt),
        .dflush_done      (dflush_done),
        .pc_en            (pc_en),
        .fl_en            (fl_en),
        .fl_flush         (fl_flush),
        .dl_en            (dl_en),
        .dl_flush         (dl_flush),
        .el_en            (el_en),
        .el_flush         (el_flush),
        .ml_en            (ml_en),
        .ml_flush         (ml_flush),
        .dflush_req       (dflush_req),
        .halted           (halted),
        .stall_cnt        (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; mem_dren = 1'b0; mem_dwen = 1'b0;
        ex_memread = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        id_jump = 1'b0; mem_branch_taken = 1'b0; wb_halt = 1'b0;
        dflush_done = 1'b0;
    endtask

    // Advance one cycle; return 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0;
        idle();
        #12;
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_dfreq", 32'(dflush_req), 32'd0);
        nRST = 1'b1;
        #1;
        chk("idle_ctl", 32'(ctl), 32'(C_IDLE));
        tick();
        chk("idle_cnt", 32'(stall_cnt), 32'd0);

        // Load-use via rs
        ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #1;
        chk("lu_rs_ctl", 32'(ctl), 32'(C_LOADU));
        tick();
        chk("lu_rs_cnt", 32'(stall_cnt), 32'd1);

        // Load to r0 never stalls
        ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        chk("lu_r0_ctl", 32'(ctl), 32'(C_IDLE));
        tick();
        chk("lu_r0_cnt", 32'(stall_cnt), 32'd1);

        // Load-use via rt
        ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7;
        #1;
        chk("lu_rt_ctl", 32'(ctl), 32'(C_LOADU));
        tick();
        chk("lu_rt_cnt", 32'(stall_cnt), 32'd2);

        // Branch overrides load-use
        mem_branch_taken = 1'b1;
        #1;
        chk("br_lu_ctl", 32'(ctl), 32'(C_BRANCH));
        tick();
        chk("br_lu_cnt", 32'(stall_cnt), 32'd2);

        // Memory stall freezes everything, branch included
        mem_dren = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("freeze_ctl", 32'(ctl), 32'(C_NONE));
            tick();
        end
        chk("freeze_cnt", 32'(stall_cnt), 32'd5);

        // Access completes: branch redirect applies this cycle
        dhit = 1'b1;
        #1;
        chk("br_dhit_ctl", 32'(ctl), 32'(C_BRANCH));
        tick();
        chk("br_dhit_cnt", 32'(stall_cnt), 32'd5);

        // Store miss alone also freezes
        idle();
        mem_dwen = 1'b1; dhit = 1'b0;
        #1;
        chk("st_freeze_ctl", 32'(ctl), 32'(C_NONE));
        tick();
        chk("st_freeze_cnt", 32'(stall_cnt), 32'd6);

        // Jump beats instruction miss
        idle();
        ihit = 1'b0; id_jump = 1'b1;
        #1;
        chk("jump_ctl", 32'(ctl), 32'(C_JUMP));
        tick();
        chk("jump_cnt", 32'(stall_cnt), 32'd6);

        // Instruction miss alone
        id_jump = 1'b0;
        #1;
        chk("imiss_ctl", 32'(ctl), 32'(C_IMISS));
        tick();
        chk("imiss_cnt", 32'(stall_cnt), 32'd7);

        // dflush_done in RUN is ignored
        idle();
        dflush_done = 1'b1;
        #1;
        chk("dfd_run_req", 32'(dflush_req), 32'd0);
        tick();
        chk("dfd_run_ctl", 32'(ctl), 32'(C_IDLE));
        chk("dfd_run_halted", 32'(halted), 32'd0);
        dflush_done = 1'b0;

        // HALT retires: pipeline stops, FLUSH next cycle
        wb_halt = 1'b1;
        #1;
        chk("halt_ctl", 32'(ctl), 32'(C_NONE));
        chk("halt_req", 32'(dflush_req), 32'd0);
        tick();
        wb_halt = 1'b0;
        #1;
        chk("fl_req", 32'(dflush_req), 32'd1);
        chk("fl_ctl", 32'(ctl), 32'(C_NONE));
        chk("fl_cnt", 32'(stall_cnt), 32'd8);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fl_wait_req", 32'(dflush_req), 32'd1);
            chk("fl_wait_halted", 32'(halted), 32'd0);
        end
        dflush_done = 1'b1;
        #1;
        chk("fl_done_req", 32'(dflush_req), 32'd1);
        chk("fl_done_halted", 32'(halted), 32'd0);
        tick();
        chk("halted", 32'(halted), 32'd1);
        chk("halted_req", 32'(dflush_req), 32'd0);
        chk("halted_ctl", 32'(ctl), 32'(C_NONE));

        // HALTED is sticky
        idle();
        wb_halt = 1'b1; dflush_done = 1'b1;
        tick();
        wb_halt = 1'b0;
        tick();
        tick();
        chk("sticky_halted", 32'(halted), 32'd1);
        chk("sticky_ctl", 32'(ctl), 32'(C_NONE));
        chk("sticky_cnt", 32'(stall_cnt), 32'd8);

        // Reset mid-FLUSH
        idle();
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
        tick();
        wb_halt = 1'b1;
        tick();
        wb_halt = 1'b0;
        #1;
        chk("rf_req_pre", 32'(dflush_req), 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        chk("rf_req", 32'(dflush_req), 32'd0);
        chk("rf_halted", 32'(halted), 32'd0);
        chk("rf_cnt", 32'(stall_cnt), 32'd0);
        chk("rf_ctl", 32'(ctl), 32'(C_IDLE));
        tick();
        nRST = 1'b1;
        tick();
        chk("rf_run_ctl", 32'(ctl), 32'(C_IDLE));

        // Saturation of the stall counter
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
        ex_memread = 1'b1; ex_rt = 5'd9; id_rt = 5'd9;
        for (int i = 0; i < (1 << CW) - 2; i++)
            tick();
        chk("sat_pre", 32'(stall_cnt), 32'((1 << CW) - 2));
        for (int i = 0; i < 7; i++)
            tick();
        chk("sat_cnt", 32'(stall_cnt), 32'((1 << CW) - 1));
        chk("sat_ctl", 32'(ctl), 32'(C_LOADU));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
